// File: rtl/sort_seq_pkg.sv
// Shared constants for the sequential block sorter: FSM state encodings,
// default geometry and the index-width helper.
package sort_seq_pkg;

  localparam int DEF_DW = 4;
  localparam int DEF_N  = 4;

  typedef logic [1:0] state_t;

  localparam state_t LOAD  = 2'd0;
  localparam state_t SORT  = 2'd1;
  localparam state_t DRAIN = 2'd2;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_seq_mag_cmp.sv
// Unsigned magnitude comparator shared by every compare-and-swap step of
// the sorter; exactly one of gt/lt/eq is high.
module mag_cmp #(
  parameter int DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          gt,
  output logic          lt,
  output logic          eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/sort_seq_ctrl.sv
// Block bubble-sorter: loads N words, sorts them in place one compare per
// cycle, then streams them out. Define SORT_DESCEND_EN for descending order.
module sort_seq_ctrl
  import sort_seq_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int N  = DEF_N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

`ifdef SORT_DESCEND_EN
  localparam bit DESCEND = 1'b1;
`else
  localparam bit DESCEND = 1'b0;
`endif

  state_t        state;
  logic [DW-1:0] mem [N];
  logic [IW-1:0] wr, rd, j, p;
  logic          swapped;

  logic [IW-1:0] j1;
  logic [DW-1:0] cmp_a, cmp_b;
  logic          gt, lt, eq;
  logic          do_swap, pass_end;

  assign j1    = j + IW'(1);
  assign cmp_a = mem[j];
  assign cmp_b = mem[j1];

  mag_cmp #(.DW(DW)) u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .gt (gt),
    .lt (lt),
    .eq (eq)
  );

  // Equal words never swap, which keeps the sort stable in both orders.
  assign do_swap  = ~eq & (DESCEND ? lt : gt);
  assign pass_end = (j == (LAST_PASS - p));

  // A pass ends early when it made no swap, or after the last possible pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= LOAD;
      wr      <= '0;
      rd      <= '0;
      j       <= '0;
      p       <= '0;
      swapped <= 1'b0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            mem[wr] <= in_data;
            wr      <= wr + IW'(1);
            if (wr == LAST_IDX) begin
              state   <= SORT;
              j       <= '0;
              p       <= '0;
              swapped <= 1'b0;
            end
          end
        end
        SORT: begin
          if (do_swap) begin
            mem[j]  <= cmp_b;
            mem[j1] <= cmp_a;
          end
          if (pass_end) begin
            if (!(swapped | do_swap) || (p == LAST_PASS)) begin
              state <= DRAIN;
              rd    <= '0;
            end else begin
              p <= p + IW'(1);
            end
            j       <= '0;
            swapped <= 1'b0;
          end else begin
            j       <= j1;
            swapped <= swapped | do_swap;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd == LAST_IDX) begin
              state <= LOAD;
              rd    <= '0;
              wr    <= '0;
            end else begin
              rd <= rd + IW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DRAIN);
  assign busy      = (state != LOAD);
  assign out_data  = out_valid ? mem[rd] : '0;
  assign out_last  = out_valid & (rd == LAST_IDX);

endmodule
